gshare_bp: RTL

GSHARE_BP -- requirements
Module: gshare_bp

---
 rtl/gshare_bp.sv | 138 +++++++++++++
 1 files changed

// File: rtl/gshare_bp.sv
// gshare_bp: gshare branch predictor.
// The fetch index is the branch tag XOR the global history register (ghr).
// Each table entry is a saturating counter whose MSB is the taken prediction.
// Fetch reads the table combinationally. Commit trains the table, and a
// mispredict restores the history from the committed snapshot.
// Optional feature: define BP_STATS_EN to enable the commit/mispredict
// statistics counters. Without it, the statistics ports are tied to zero.
module gshare_bp #(
    parameter int IDX_W = 8,
    parameter int CNT_W = 2,
    parameter int GHR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             in_fetcher_valid,
    input  logic [IDX_W-1:0] in_fetcher_tag,
    output logic             out_fetcher_jump_res,
    output logic [GHR_W-1:0] out_fetcher_ghr,
    input  logic             in_rob_bp_res,
    input  logic [IDX_W-1:0] in_rob_tag,
    input  logic [GHR_W-1:0] in_rob_ghr,
    input  logic             in_rob_jump_res,
    input  logic             in_rob_mispredict,
    output logic [31:0]      out_stat_commits,
    output logic [31:0]      out_stat_miss
);

    localparam int              DEPTH   = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] table_q [DEPTH];
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;
    logic [GHR_W-1:0] spec_ghr;
    logic [GHR_W-1:0] repair_ghr;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] commit_idx;
    logic [CNT_W-1:0] commit_cnt;
    logic [CNT_W-1:0] commit_cnt_next;
    logic             commit_en;

    // Both indices hash the tag with the zero-extended history.
    assign fetch_idx  = in_fetcher_tag ^ IDX_W'(ghr_q);
    assign commit_idx = in_rob_tag ^ IDX_W'(in_rob_ghr);
    assign commit_en  = rdy && in_rob_bp_res;

    // The fetch port reads the registered table. A commit to the same entry
    // in the same cycle therefore becomes visible only after the clock edge.
    assign out_fetcher_jump_res = table_q[fetch_idx][CNT_W-1];
    assign out_fetcher_ghr      = ghr_q;

    // The shifted-history forms need special handling when the history is one bit.
    generate
        if (GHR_W == 1) begin : g_ghr_one
            assign spec_ghr   = out_fetcher_jump_res;
            assign repair_ghr = in_rob_jump_res;
        end else begin : g_ghr_wide
            assign spec_ghr   = {ghr_q[GHR_W-2:0], out_fetcher_jump_res};
            assign repair_ghr = {in_rob_ghr[GHR_W-2:0], in_rob_jump_res};
        end
    endgenerate

    // Next history: a mispredict repair overrides the speculative fetch shift.
    always_comb begin
        // NOTE: assigning a default first on every path keeps always_comb from inferring a latch.
        ghr_d = ghr_q;
        if (in_rob_bp_res && in_rob_mispredict) begin
            ghr_d = repair_ghr;
        end else if (in_fetcher_valid) begin
            ghr_d = spec_ghr;
        end
    end

    // Saturating increment or decrement of the committing counter.
    always_comb begin
        commit_cnt      = table_q[commit_idx];
        commit_cnt_next = commit_cnt;
        if (in_rob_jump_res) begin
            if (commit_cnt != CNT_MAX) begin
                commit_cnt_next = commit_cnt + CNT_W'(1);
            end
        end else begin
            if (commit_cnt != '0) begin
                commit_cnt_next = commit_cnt - CNT_W'(1);
            end
        end
    end

    // History register. Only updated while the predictor is enabled.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
        if (!rst) begin
            ghr_q <= '0;
        end else if (rdy) begin
            ghr_q <= ghr_d;
        end
    end

    // Counter table. Reset sets every entry to strongly taken.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the table is built from flops rather than a RAM macro because reset must initialise every entry.
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= CNT_MAX;
            end
        end else if (commit_en) begin
            table_q[commit_idx] <= commit_cnt_next;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] commits_q;
    logic [31:0] miss_q;

    // Commit and mispredict counters. Both saturate at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commits_q <= '0;
            miss_q    <= '0;
        end else if (commit_en) begin
            if (commits_q != '1) begin
                commits_q <= commits_q + 32'd1;
            end
            if (in_rob_mispredict && (miss_q != '1)) begin
                miss_q <= miss_q + 32'd1;
            end
        end
    end

    assign out_stat_commits = commits_q;
    assign out_stat_miss    = miss_q;
`else
    assign out_stat_commits = 32'd0;
    assign out_stat_miss    = 32'd0;
`endif

endmodule
